// File: rtl/debug_pkg.sv
// Shared widths, FSM state encoding and small helpers for the debug event queue.
package debug_pkg;

    localparam int DEBUG_WORD_W = 40;
    localparam int DEBUG_TAG_W  = 8;
    localparam int DEBUG_VAL_W  = 32;

    // Issue handshake states; the encoding is shared so that any observer
    // (for example a debug mux) decodes the same values.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_ACK  = 2'd2,
        WAIT_DONE = 2'd3
    } dq_state_t;

    // Tag occupies the upper byte so the value's bit 0 is serialized first.
    function automatic logic [DEBUG_WORD_W-1:0] pack_word(
        input logic [DEBUG_TAG_W-1:0] tag,
        input logic [DEBUG_VAL_W-1:0] value
    );
        return {tag, value};
    endfunction

    // Increment that sticks at the all-ones value.
    function automatic logic [7:0] sat_inc8(input logic [7:0] cnt);
        return (cnt == 8'hFF) ? cnt : cnt + 8'd1;
    endfunction

endpackage

// File: rtl/debug_fifo.sv
// Single-clock synchronous FIFO holding debug words; depth is a power of two.
module debug_fifo
    import debug_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = DEBUG_WORD_W
) (
    input  logic                     in_clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    level_q, level_d;
    logic              push_ok;
    logic              pop_ok;

    assign full  = (level_q == (PTR_W+1)'(DEPTH));
    assign empty = (level_q == '0);
    assign level = level_q;
    assign rdata = mem_q[rd_ptr_q];

    // Guard against overflow/underflow; full is judged before any same-cycle pop.
    always_comb begin
        push_ok  = push && !full;
        pop_ok   = pop && !empty;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + (PTR_W+1)'(1);
            2'b01:   level_d = level_q - (PTR_W+1)'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointer and occupancy registers; pointers wrap naturally at DEPTH.
    always_ff @(posedge in_clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage array; contents need no reset because occupancy gates reads.
    always_ff @(posedge in_clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/debug_data_queue.sv
// Buffers debug events and hands them one at a time to a serializer using a
// store/busy handshake with a re-issue timeout; counts events lost to overflow.
module debug_data_queue
    import debug_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int ACK_TIMEOUT = 8
) (
    input  logic                      in_clk,
    input  logic                      reset,
    input  logic                      ev_valid,
    input  logic [DEBUG_TAG_W-1:0]    ev_tag,
    input  logic [DEBUG_VAL_W-1:0]    ev_value,
    output logic                      ev_ready,
    input  logic                      sender_busy,
    output logic                      store,
    output logic [DEBUG_WORD_W-1:0]   data,
    output logic [$clog2(DEPTH):0]    level,
    output logic [7:0]                dropped
);

    localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

    dq_state_t                 state_q, state_d;
    logic [DEBUG_WORD_W-1:0]   data_q, data_d;
    logic [TMR_W-1:0]          timer_q, timer_d;
    logic [7:0]                dropped_q, dropped_d;

    logic                      fifo_push;
    logic                      fifo_pop;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [DEBUG_WORD_W-1:0]   fifo_rdata;

    assign fifo_push = ev_valid;
    assign ev_ready  = !fifo_full;
    assign store     = (state_q == ISSUE);
    assign data      = data_q;
    assign dropped   = dropped_q;

    debug_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DEBUG_WORD_W)
    ) u_fifo (
        .in_clk (in_clk),
        .reset  (reset),
        .push   (fifo_push),
        .wdata  (pack_word(ev_tag, ev_value)),
        .pop    (fifo_pop),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .level  (level)
    );

    // Handshake next-state: pop the head on IDLE->ISSUE, re-issue on ack timeout.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        timer_d  = timer_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && !sender_busy) begin
                    state_d  = ISSUE;
                    data_d   = fifo_rdata;
                    fifo_pop = 1'b1;
                end
            end
            ISSUE: begin
                state_d = WAIT_ACK;
                timer_d = '0;
            end
            WAIT_ACK: begin
                if (sender_busy) begin
                    state_d = WAIT_DONE;
                    timer_d = '0;
                end else if (timer_q == TMR_W'(ACK_TIMEOUT - 1)) begin
                    state_d = ISSUE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!sender_busy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Overflow counter: an event offered while full is lost even if a pop coincides.
    always_comb begin
        dropped_d = dropped_q;
        if (ev_valid && fifo_full) begin
            dropped_d = sat_inc8(dropped_q);
        end
    end

    // Control and output registers; reset clears any word in flight.
    always_ff @(posedge in_clk) begin
        if (reset) begin
            state_q   <= IDLE;
            data_q    <= '0;
            timer_q   <= '0;
            dropped_q <= '0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            timer_q   <= timer_d;
            dropped_q <= dropped_d;
        end
    end

endmodule

// File: tb/tb_debug_data_queue.sv
// Bench for debug_data_queue: directed scenarios plus a randomized run against
// a queue-based reference model of the store/busy handshake.
module tb_debug_data_queue;

    localparam int DEPTH = 4;
    localparam int ACK   = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          in_clk = 1'b0;
    logic          reset = 1'b0;
    logic          ev_valid = 1'b0;
    logic [7:0]    ev_tag = '0;
    logic [31:0]   ev_value = '0;
    logic          ev_ready;
    logic          sender_busy = 1'b0;
    logic          store;
    logic [39:0]   data;
    logic [LW-1:0] level;
    logic [7:0]    dropped;

    int errors = 0;
    int checks = 0;

    always #5 in_clk = ~in_clk;

    debug_data_queue #(
        .DEPTH       (DEPTH),
        .ACK_TIMEOUT (ACK)
    ) dut (
        .in_clk      (in_clk),
        .reset       (reset),
        .ev_valid    (ev_valid),
        .ev_tag      (ev_tag),
        .ev_value    (ev_value),
        .ev_ready    (ev_ready),
        .sender_busy (sender_busy),
        .store       (store),
        .data        (data),
        .level       (level),
        .dropped     (dropped)
    );

    task automatic step();
        @(posedge in_clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        ev_valid = 1'b0;
        sender_busy = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ev_valid = 1'b1;
        ev_tag = 8'hFF;
        ev_value = $urandom();
        sender_busy = 1'b0;
        step();
        step();
        checks++; if (level !== LW'(0)) begin errors++; $display("FAIL reset_level got=%0d exp=0", level); end
        checks++; if (store !== 1'b0) begin errors++; $display("FAIL reset_store got=%b exp=0", store); end
        checks++; if (data !== 40'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", data); end
        checks++; if (dropped !== 8'd0) begin errors++; $display("FAIL reset_dropped got=%0d exp=0", dropped); end
        checks++; if (ev_ready !== 1'b1) begin errors++; $display("FAIL reset_ev_ready got=%b exp=1", ev_ready); end
        ev_valid = 1'b0;
        reset = 1'b0;
    endtask

    task automatic test_single_event();
        logic [39:0] w2;
        do_reset();
        ev_valid = 1'b1; ev_tag = 8'hA5; ev_value = 32'h12345678;
        step();                                   // push at N
        ev_valid = 1'b0;
        checks++; if (store !== 1'b0 || level !== LW'(1)) begin errors++; $display("FAIL single_n got store=%b level=%0d exp store=0 level=1", store, level); end
        step();                                   // N+1: IDLE->ISSUE
        checks++; if (store !== 1'b1) begin errors++; $display("FAIL single_store_n2 got=%b exp=1", store); end
        checks++; if (data !== 40'hA512345678) begin errors++; $display("FAIL single_data got=%h exp=a512345678", data); end
        // queue a second word, one-cycle busy pulse: next store at minimum spacing
        w2 = {8'h5A, 32'hCAFEF00D};
        ev_valid = 1'b1; ev_tag = 8'h5A; ev_value = 32'hCAFEF00D;
        step();                                   // S+1
        ev_valid = 1'b0;
        checks++; if (store !== 1'b0 || level !== LW'(1)) begin errors++; $display("FAIL single_s1 got store=%b level=%0d exp store=0 level=1", store, level); end
        sender_busy = 1'b1;
        step();                                   // S+2: WAIT_DONE
        sender_busy = 1'b0;
        checks++; if (store !== 1'b0 || data !== 40'hA512345678) begin errors++; $display("FAIL single_s2 got store=%b data=%h exp store=0 data=a512345678", store, data); end
        step();                                   // S+3: IDLE
        checks++; if (store !== 1'b0) begin errors++; $display("FAIL single_s3 got store=%b exp=0", store); end
        step();                                   // S+4: ISSUE
        checks++; if (store !== 1'b1 || data !== w2 || level !== LW'(0)) begin errors++; $display("FAIL single_s4 got store=%b data=%h level=%0d exp store=1 data=%h level=0", store, data, level, w2); end
    endtask

    task automatic test_burst();
        do_reset();
        sender_busy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ev_valid = 1'b1; ev_tag = 8'(i + 1); ev_value = $urandom();
            step();
            if (i == 2) begin
                checks++; if (ev_ready !== 1'b1) begin errors++; $display("FAIL burst_ready3 got=%b exp=1", ev_ready); end
            end
            if (i == 3) begin
                checks++; if (ev_ready !== 1'b0) begin errors++; $display("FAIL burst_ready4 got=%b exp=0", ev_ready); end
            end
        end
        ev_valid = 1'b0;
        checks++; if (dropped !== 8'd2) begin errors++; $display("FAIL burst_dropped got=%0d exp=2", dropped); end
        checks++; if (level !== LW'(4)) begin errors++; $display("FAIL burst_level got=%0d exp=4", level); end
        checks++; if (store !== 1'b0) begin errors++; $display("FAIL burst_store got=%b exp=0", store); end
    endtask

    // Continues from the full queue left by test_burst (dropped=2, busy held).
    task automatic test_saturation();
        for (int i = 0; i < 300; i++) begin
            ev_valid = 1'b1; ev_tag = 8'hEE; ev_value = $urandom();
            step();
            if (i == 251) begin
                checks++; if (dropped !== 8'd254) begin errors++; $display("FAIL sat_mid got=%0d exp=254", dropped); end
            end
        end
        checks++; if (dropped !== 8'd255) begin errors++; $display("FAIL sat_300 got=%0d exp=255", dropped); end
        for (int i = 0; i < 10; i++) step();
        ev_valid = 1'b0;
        checks++; if (dropped !== 8'd255 || level !== LW'(4)) begin errors++; $display("FAIL sat_hold got dropped=%0d level=%0d exp dropped=255 level=4", dropped, level); end
    endtask

    task automatic test_drain_order();
        logic [39:0] exp_w[4];
        int n;
        int bs;
        int last;
        do_reset();
        sender_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            ev_valid = 1'b1; ev_tag = 8'(i + 1); ev_value = $urandom();
            exp_w[i] = {ev_tag, ev_value};
            step();
        end
        ev_valid = 1'b0;
        sender_busy = 1'b0;
        n = 0; bs = -1; last = -1;
        for (int c = 0; c < 400; c++) begin
            step();
            if (store === 1'b1) begin
                if (n < 4) begin
                    checks++; if (data !== exp_w[n]) begin errors++; $display("FAIL drain_word%0d got=%h exp=%h", n, data, exp_w[n]); end
                end
                if (n > 0) begin
                    checks++; if (c - last != 48) begin errors++; $display("FAIL drain_spacing%0d got=%0d exp=48", n, c - last); end
                end
                n++; last = c; bs = c + 2;
            end
            sender_busy = (bs >= 0 && (c + 1) >= bs && (c + 1) < bs + 45);
        end
        sender_busy = 1'b0;
        checks++; if (n != 4) begin errors++; $display("FAIL drain_count got=%0d exp=4", n); end
        checks++; if (level !== LW'(0)) begin errors++; $display("FAIL drain_level got=%0d exp=0", level); end
    endtask

    task automatic test_no_ack();
        logic [39:0] wa;
        int stray;
        do_reset();
        ev_valid = 1'b1; ev_tag = 8'h3C; ev_value = $urandom();
        wa = {ev_tag, ev_value};
        step();                                   // push A
        ev_tag = 8'h3D; ev_value = $urandom();
        step();                                   // push B, issue A
        ev_valid = 1'b0;
        checks++; if (store !== 1'b1 || data !== wa || level !== LW'(1)) begin errors++; $display("FAIL noack_first got store=%b data=%h level=%0d exp store=1 data=%h level=1", store, data, level, wa); end
        stray = 0;
        for (int i = 0; i < ACK; i++) begin
            step();
            if (store !== 1'b0) stray++;
        end
        checks++; if (stray != 0) begin errors++; $display("FAIL noack_quiet got=%0d exp=0 stores", stray); end
        step();
        checks++; if (store !== 1'b1 || data !== wa || level !== LW'(1)) begin errors++; $display("FAIL noack_reissue got store=%b data=%h level=%0d exp store=1 data=%h level=1", store, data, level, wa); end
    endtask

    task automatic test_reset_mid();
        int stray;
        do_reset();
        sender_busy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            ev_valid = 1'b1; ev_tag = 8'(i + 16); ev_value = $urandom();
            step();
        end
        ev_valid = 1'b0;
        sender_busy = 1'b0;
        step();                                   // ISSUE
        sender_busy = 1'b1;
        step();                                   // WAIT_ACK
        step();                                   // WAIT_DONE
        checks++; if (level !== LW'(3) || dropped !== 8'd2) begin errors++; $display("FAIL rmid_pre got level=%0d dropped=%0d exp level=3 dropped=2", level, dropped); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (level !== LW'(0) || store !== 1'b0 || dropped !== 8'd0 || ev_ready !== 1'b1 || data !== 40'h0) begin
            errors++; $display("FAIL rmid_post got level=%0d store=%b dropped=%0d ready=%b data=%h exp 0/0/0/1/0", level, store, dropped, ev_ready, data);
        end
        sender_busy = 1'b0;
        stray = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (store !== 1'b0) stray++;
        end
        checks++; if (stray != 0 || level !== LW'(0)) begin errors++; $display("FAIL rmid_quiet got stores=%0d level=%0d exp 0/0", stray, level); end
        ev_valid = 1'b1; ev_tag = 8'h77; ev_value = 32'h1;
        step();
        ev_valid = 1'b0;
        step();
        checks++; if (store !== 1'b1 || data !== 40'h7700000001) begin errors++; $display("FAIL rmid_restart got store=%b data=%h exp store=1 data=7700000001", store, data); end
    endtask

    task automatic test_random();
        logic [39:0] mq[$];
        int mdrop, mph, mwait;
        logic [39:0] mdata;
        logic m_full;
        int sd_delay, sd_hold, sd_h, shown, rate;
        logic [51:0] got, exp;
        do_reset();
        mq.delete();
        mdrop = 0; mph = 0; mwait = 0; mdata = '0;
        sd_delay = -1; sd_hold = 0; sd_h = 1; shown = 0;
        for (int c = 0; c < 3000; c++) begin
            // serializer behaviour: delayed acknowledge, random hold time
            if (sd_hold > 0) begin sender_busy = 1'b1; sd_hold--; end
            else if (sd_delay > 0) begin sender_busy = 1'b0; sd_delay--; end
            else if (sd_delay == 0) begin sender_busy = 1'b1; sd_hold = sd_h - 1; sd_delay = -1; end
            else sender_busy = 1'b0;
            rate = ((c / 500) % 2 == 1) ? 85 : 20;
            ev_valid = ($urandom_range(0, 99) < rate);
            ev_tag = 8'($urandom());
            ev_value = $urandom();
            // reference: occupancy judged before the edge, drops saturate
            m_full = (mq.size() == DEPTH);
            if (ev_valid && m_full && mdrop < 255) mdrop++;
            case (mph)
                0: if (mq.size() > 0 && !sender_busy) begin mdata = mq.pop_front(); mph = 1; end
                1: begin mph = 2; mwait = 0; end
                2: if (sender_busy) mph = 3;
                   else if (mwait == ACK - 1) mph = 1;
                   else mwait++;
                default: if (!sender_busy) mph = 0;
            endcase
            if (ev_valid && !m_full) mq.push_back({ev_tag, ev_value});
            step();
            got = {store, data, 3'(level), dropped};
            exp = {(mph == 1), mdata, 3'(mq.size()), 8'(mdrop)};
            checks++;
            if (got !== exp || ev_ready !== (mq.size() < DEPTH)) begin
                errors++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL random_c%0d got store=%b data=%h level=%0d dropped=%0d ready=%b exp store=%b data=%h level=%0d dropped=%0d",
                             c, store, data, level, dropped, ev_ready, (mph == 1), mdata, mq.size(), mdrop);
                end
            end
            if (store === 1'b1 && sd_delay < 0 && sd_hold == 0 && !sender_busy) begin
                sd_delay = $urandom_range(0, 11);
                sd_h = $urandom_range(1, 6);
            end
        end
        ev_valid = 1'b0;
        sender_busy = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_event();
        test_burst();
        test_saturation();
        test_drain_order();
        test_no_ack();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
